// File: rtl/burst_cmd_ram.sv
// burst_cmd_ram: command-driven single-port RAM slave behind the SPI front-end.
// Command word = {opcode[1:0], payload[DATA_WIDTH-1:0]}:
//   00 SET_WADDR, 01 WRITE, 10 SET_RADDR, 11 READ.
// Read data leaves on a valid/ready slot; a READ that finds the slot full
// is dropped and raises the sticky overrun flag.
// Optional feature macro: AUTO_INC_EN (post-increment wr_addr on WRITE and
// rd_addr on accepted READ, wrapping modulo 2**ADDR_SIZE).
module burst_cmd_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  overrun
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  localparam logic [1:0] OP_SET_WADDR = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_SET_RADDR = 2'b10;
  localparam logic [1:0] OP_READ      = 2'b11;

`ifdef AUTO_INC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  mem_we;

  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] payload;
  logic                  slot_free;

  assign op        = din[DATA_WIDTH+1:DATA_WIDTH];
  assign payload   = din[DATA_WIDTH-1:0];
  // The slot is free when empty, or when its current word leaves this cycle.
  assign slot_free = !tx_valid_q || tx_ready;

  // Decode the command and work out next state for addresses and the output slot.
  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    overrun_d  = overrun_q;
    mem_we     = 1'b0;

    // Consumer takes the word; a READ accepted below re-fills the slot.
    if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end

    if (rx_valid) begin
      case (op)
        OP_SET_WADDR: wr_addr_d = payload[ADDR_SIZE-1:0];
        OP_WRITE: begin
          mem_we = 1'b1;
          if (AutoInc) wr_addr_d = wr_addr_q + 1'b1;
        end
        OP_SET_RADDR: rd_addr_d = payload[ADDR_SIZE-1:0];
        OP_READ: begin
          if (slot_free) begin
            dout_d     = mem_q[rd_addr_q];
            tx_valid_d = 1'b1;
            if (AutoInc) rd_addr_d = rd_addr_q + 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state and read data register; reset clears everything but memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Memory array: not reset, and a command coinciding with reset is ignored.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[wr_addr_q] <= payload;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_burst_cmd_ram.sv
// tb_burst_cmd_ram: directed and randomized bench for burst_cmd_ram with a
// behavioural model (plain arrays and counters) checked on every cycle.
module tb_burst_cmd_ram;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic       tx_ready;
  logic [7:0] dout;
  logic       tx_valid;
  logic       overrun;

  // Second instance at DATA_WIDTH=16, ADDR_SIZE=4
  logic        p_rst_n;
  logic [17:0] p_din;
  logic        p_rx_valid;
  logic        p_tx_ready;
  logic [15:0] p_dout;
  logic        p_tx_valid;
  logic        p_overrun;

  int vectors;
  int miscompares;

  burst_cmd_ram #(.DATA_WIDTH(8), .ADDR_SIZE(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .tx_ready(tx_ready), .dout(dout), .tx_valid(tx_valid), .overrun(overrun)
  );

  burst_cmd_ram #(.DATA_WIDTH(16), .ADDR_SIZE(4)) u_dut_p (
    .clk(clk), .rst_n(p_rst_n), .din(p_din), .rx_valid(p_rx_valid),
    .tx_ready(p_tx_ready), .dout(p_dout), .tx_valid(p_tx_valid), .overrun(p_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef AUTO_INC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_wa, m_ra, m_dout;
  bit         m_vld, m_ovr, m_dout_known;
  bit         m_free, m_took;
  bit         chk_en;

  initial begin
    chk_en = 1'b0;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_wa = 8'h00; m_ra = 8'h00; m_dout = 8'h00;
      m_vld = 1'b0; m_ovr = 1'b0; m_dout_known = 1'b1;
    end else begin
      m_free = !m_vld || tx_ready;
      m_took = 1'b0;
      if (rx_valid) begin
        if (din[9:8] == 2'd0) m_wa = din[7:0];
        else if (din[9:8] == 2'd1) begin
          m_mem[m_wa] = din[7:0];
          m_known[m_wa] = 1'b1;
          if (AUTO) m_wa = m_wa + 8'd1;
        end else if (din[9:8] == 2'd2) m_ra = din[7:0];
        else begin
          if (m_free) begin
            m_dout = m_mem[m_ra];
            m_dout_known = m_known[m_ra];
            m_took = 1'b1;
            if (AUTO) m_ra = m_ra + 8'd1;
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
      if (m_took) m_vld = 1'b1;
      else if (m_vld && tx_ready) m_vld = 1'b0;
    end
  end

  // Per-cycle comparison of DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (tx_valid !== m_vld || overrun !== m_ovr ||
          (m_dout_known && dout !== m_dout)) begin
        miscompares++;
        $display("FAIL model t=%0t: dout=%h tx_valid=%b overrun=%b, expected dout=%h tx_valid=%b overrun=%b",
                 $time, dout, tx_valid, overrun, m_dout, m_vld, m_ovr);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic lchk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus; returns just after the edge that consumed it.
  task automatic cyc(input bit rn, input bit rv, input logic [1:0] op, input logic [7:0] pl, input bit rdy);
    rst_n    = rn;
    rx_valid = rv;
    din      = {op, pl};
    tx_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic pcyc(input bit rn, input bit rv, input logic [1:0] op, input logic [15:0] pl, input bit rdy);
    p_rst_n    = rn;
    p_rx_valid = rv;
    p_din      = {op, pl};
    p_tx_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; rx_valid = 1'b0; din = '0; tx_ready = 1'b0;
    p_rst_n = 1'b0; p_rx_valid = 1'b0; p_din = '0; p_tx_ready = 1'b0;

    // Reset then idle
    cyc(0, 0, 2'd0, 8'h00, 0);
    chk_en = 1'b1;
    cyc(0, 0, 2'd0, 8'h00, 0);
    lchk("rst_dout", {24'd0, dout}, 32'h0);
    lchk("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
    lchk("rst_overrun", {31'd0, overrun}, 32'h0);
    repeat (3) cyc(1, 0, 2'd0, 8'h00, 1);
    lchk("idle_tx_valid", {31'd0, tx_valid}, 32'h0);

    // Basic write/read
    cyc(1, 1, 2'd0, 8'h3C, 1);
    cyc(1, 1, 2'd1, 8'hA5, 1);
    cyc(1, 1, 2'd2, 8'h3C, 1);
    cyc(1, 1, 2'd3, 8'h00, 1);
    lchk("basic_dout", {24'd0, dout}, 32'hA5);
    lchk("basic_valid", {31'd0, tx_valid}, 32'h1);
    cyc(1, 0, 2'd0, 8'h00, 1);
    lchk("basic_consumed", {31'd0, tx_valid}, 32'h0);

    // Burst across the FF->00 wrap
    cyc(1, 1, 2'd0, 8'hFE, 1);
    cyc(1, 1, 2'd1, 8'h11, 1);
    if (!AUTO) cyc(1, 1, 2'd0, 8'hFF, 1);
    cyc(1, 1, 2'd1, 8'h22, 1);
    if (!AUTO) cyc(1, 1, 2'd0, 8'h00, 1);
    cyc(1, 1, 2'd1, 8'h33, 1);
    cyc(1, 1, 2'd2, 8'hFE, 1);
    cyc(1, 1, 2'd3, 8'h00, 1);
    lchk("burst0", {23'd0, tx_valid, dout}, 32'h111);
    if (!AUTO) cyc(1, 1, 2'd2, 8'hFF, 0);
    cyc(1, 1, 2'd3, 8'h00, 1);
    lchk("burst1", {23'd0, tx_valid, dout}, 32'h122);
    if (!AUTO) cyc(1, 1, 2'd2, 8'h00, 0);
    cyc(1, 1, 2'd3, 8'h00, 1);
    lchk("burst2_wrap", {23'd0, tx_valid, dout}, 32'h133);
    cyc(1, 0, 2'd0, 8'h00, 1);

    // Backpressure and overrun
    cyc(1, 1, 2'd0, 8'h3D, 0);
    cyc(1, 1, 2'd1, 8'h5A, 0);
    cyc(1, 1, 2'd2, 8'h3C, 0);
    cyc(1, 1, 2'd3, 8'h00, 0);
    lchk("bp_first", {22'd0, overrun, tx_valid, dout}, 32'h1A5);
    cyc(1, 1, 2'd3, 8'h00, 0);
    lchk("bp_overrun", {22'd0, overrun, tx_valid, dout}, 32'h3A5);
    cyc(1, 0, 2'd0, 8'h00, 1);
    lchk("bp_drain", {30'd0, overrun, tx_valid}, 32'h2);
    cyc(1, 1, 2'd3, 8'h00, 1);
    lchk("bp_next_addr", {24'd0, dout}, AUTO ? 32'h5A : 32'hA5);

    // Mid-operation reset
    cyc(1, 1, 2'd0, 8'h00, 1);
    cyc(1, 1, 2'd1, 8'hC3, 1);
    cyc(1, 1, 2'd3, 8'h00, 0);
    cyc(1, 0, 2'd0, 8'h00, 0);
    lchk("pre_rst_state", {30'd0, overrun, tx_valid}, 32'h3);
    cyc(0, 1, 2'd3, 8'h00, 0);
    lchk("mid_rst", {22'd0, overrun, tx_valid, dout}, 32'h0);
    cyc(1, 1, 2'd3, 8'h00, 1);
    lchk("post_rst_read", {23'd0, tx_valid, dout}, 32'h1C3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 8),
          2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 2) != 0));
    end
    cyc(1, 0, 2'd0, 8'h00, 1);

    // Parametrisation: upper address payload bits ignored
    pcyc(0, 0, 2'd0, 16'h0000, 0);
    pcyc(1, 1, 2'd0, 16'h00F7, 1);
    pcyc(1, 1, 2'd1, 16'hBEEF, 1);
    pcyc(1, 1, 2'd2, 16'h0007, 1);
    pcyc(1, 1, 2'd3, 16'h0000, 1);
    lchk("param_dout", {16'd0, p_dout}, 32'hBEEF);
    lchk("param_valid", {30'd0, p_overrun, p_tx_valid}, 32'h1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/burst_cmd_ram.md
# burst_cmd_ram

- Command-driven single-port RAM slave that sits behind the SPI slave front-end.
- Successor to the fixed 8-bit command RAM: data width and address width are parametrised.
- Optional address post-increment lets the master stream bursts without re-sending addresses.
- Read data is returned on a valid/ready handshake with sticky overrun detection.

## Interface
Parameters:
- DATA_WIDTH, 8, payload and memory word width; must be >= ADDR_SIZE.
- ADDR_SIZE, 8, address width; memory depth is 2**ADDR_SIZE words.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- din  in  DATA_WIDTH+2  command word: opcode din[DATA_WIDTH+1:DATA_WIDTH], payload din[DATA_WIDTH-1:0].
- rx_valid  in  1  din valid this cycle; one command consumed per asserted cycle.
- tx_ready  in  1  consumer accepts dout when tx_valid=1.
- dout  out  DATA_WIDTH  read data.
- tx_valid  out  1  dout holds unconsumed read data.
- overrun  out  1  sticky: a read command was dropped.

## Operation
- Reset (rst_n=0 at a clk edge) sets the following to 0:
  - dout, tx_valid, overrun.
  - Internal wr_addr and rd_addr.
- Memory contents are not reset.
- Reset overrides any command or handshake in the same cycle.
- Opcodes are sampled only when rx_valid=1:
  - 00 SET_WADDR: wr_addr <= payload[ADDR_SIZE-1:0]. Upper payload bits are ignored.
  - 01 WRITE: mem[wr_addr] <= payload.
  - 10 SET_RADDR: rd_addr <= payload[ADDR_SIZE-1:0].
  - 11 READ:
    - Output slot is free when tx_valid=0, or when tx_valid=1 and tx_ready=1 in that cycle.
    - If the slot is free: dout <= mem[rd_addr] and tx_valid <= 1.
    - Otherwise the read is dropped: overrun <= 1, and dout, tx_valid and rd_addr are unchanged.
- Handshake:
  - tx_valid=1 and tx_ready=1 with no accepted READ in the same cycle: tx_valid <= 0 and dout holds its last value.
  - While tx_valid=1 and tx_ready=0, dout and tx_valid are stable.
- Simultaneous handshake and READ: tx_valid stays 1 and dout takes the new word, giving back-to-back delivery.
- overrun clears only on reset.

## Timing
- READ latency: the command at edge N produces dout/tx_valid valid after edge N, i.e. visible in cycle N+1.
- WRITE is committed at edge N; a READ of the same address at edge N+1 returns the new data.
- SET_* takes effect for the command at the next edge.
- Sustained throughput is one command per cycle. Reads sustain one word per cycle while tx_ready=1.
- tx_ready is ignored when tx_valid=0.

## Configuration
- AUTO_INC_EN defined:
  - An accepted WRITE post-increments wr_addr.
  - An accepted READ post-increments rd_addr.
  - Both wrap modulo 2**ADDR_SIZE (e.g. 8'hFF -> 8'h00).
  - A dropped READ does not increment rd_addr.
- AUTO_INC_EN undefined: addresses change only via SET_WADDR/SET_RADDR. This is the legacy fixed-address behaviour.

## Test plan
- Reset then idle:
  - Stimulus: rst_n=0 for 2 cycles, then rx_valid=0.
  - Required: dout=0, tx_valid=0, overrun=0 throughout.
- Basic write/read:
  - Stimulus: SET_WADDR 8'h3C, WRITE 8'hA5, SET_RADDR 8'h3C, READ with tx_ready=1.
  - Required: dout=8'hA5 with tx_valid=1 one cycle after READ, tx_valid=0 the next cycle.
- Burst with AUTO_INC_EN:
  - Stimulus: SET_WADDR 8'hFE, WRITE 11, 22, 33; SET_RADDR 8'hFE, three back-to-back READs with tx_ready=1.
  - Required: dout 11, 22, 33 on consecutive cycles with tx_valid held at 1; the third word exercises the FF->00 wrap.
- Backpressure and overrun:
  - Stimulus: READ with tx_ready=0, then a second READ while tx_ready is still 0.
  - Required: the first word is held stable, overrun=1, rd_addr is not advanced. Raising tx_ready then delivers the first word only.
- Mid-operation reset:
  - Stimulus: assert rst_n=0 while tx_valid=1, tx_ready=0 and overrun=1.
  - Required: at the next edge all outputs are 0. After reset, a READ at address 0 returns the pre-reset memory contents.
- Parametrisation:
  - Stimulus: DATA_WIDTH=16, ADDR_SIZE=4; SET_WADDR 16'h00F7, WRITE 16'hBEEF, SET_RADDR 16'h0007, READ.
  - Required: dout=16'hBEEF, confirming the upper address payload bits are ignored.
